// File: rtl/slot_pkg.sv
// Shared definitions for the slot-machine reel sequencer: symbol width,
// FSM state encoding and spin result codes.
package slot_pkg;

  localparam int SYM_W  = 3;
  localparam int RES_W  = 2;
  localparam int REEL_N = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SPIN  = 3'd2,
    ST_STOP0 = 3'd3,
    ST_STOP1 = 3'd4,
    ST_STOP2 = 3'd5,
    ST_SCORE = 3'd6
  } state_t;

  localparam logic [RES_W-1:0] RESULT_NONE    = 2'b00;
  localparam logic [RES_W-1:0] RESULT_PAIR    = 2'b01;
  localparam logic [RES_W-1:0] RESULT_JACKPOT = 2'b10;

endpackage

// File: rtl/reel_scorer.sv
// Combinational scoring of three frozen reel symbols: jackpot when all
// three match, pair when any two match, otherwise none.
module reel_scorer
  import slot_pkg::*;
(
  input  logic [SYM_W-1:0] sym0_i,
  input  logic [SYM_W-1:0] sym1_i,
  input  logic [SYM_W-1:0] sym2_i,
  output logic [RES_W-1:0] result_o
);

  logic eq01, eq12, eq02;

  assign eq01 = (sym0_i == sym1_i);
  assign eq12 = (sym1_i == sym2_i);
  assign eq02 = (sym0_i == sym2_i);

  always_comb begin
    result_o = RESULT_NONE;
    if (eq01 && eq12) begin
      result_o = RESULT_JACKPOT;
    end else if (eq01 || eq12 || eq02) begin
      result_o = RESULT_PAIR;
    end
  end

endmodule

// File: rtl/reel_spin_ctrl.sv
// Spin sequencer for the three reel generators: clear, free-run, staggered
// left-to-right freeze, then score. All outputs are registered.
//
//   state | meaning
//   IDLE  | waiting for start; last reels/result held
//   CLEAR | one-cycle sync clear of the generators
//   SPIN  | all generators running; waits for honoured stop or auto-stop
//   STOP0 | reel 0 frozen, reels 1-2 running, STAGGER cycles
//   STOP1 | reels 0-1 frozen, reel 2 running, STAGGER cycles
//   STOP2 | all frozen, STAGGER cycles
//   SCORE | result registered, done pulse
module reel_spin_ctrl
  import slot_pkg::*;
#(
  parameter int SPIN_MIN  = 16,
  parameter int AUTO_STOP = 1024,
  parameter int STAGGER   = 8,
  parameter int CNT_W     = 11
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [SYM_W-1:0]   seed_in_i,
  input  logic [SYM_W-1:0]   rand0_i,
  input  logic [SYM_W-1:0]   rand1_i,
  input  logic [SYM_W-1:0]   rand2_i,
  output logic               rng_rst_o,
  output logic [REEL_N-1:0]  rng_en_o,
  output logic [SYM_W-1:0]   rng_seed_o,
  output logic [SYM_W-1:0]   reel0_o,
  output logic [SYM_W-1:0]   reel1_o,
  output logic [SYM_W-1:0]   reel2_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [RES_W-1:0]   result_o
);

  localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(SPIN_MIN - 1);
  localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_STOP - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                rng_rst_q;
  logic [REEL_N-1:0]   rng_en_q;
  logic [SYM_W-1:0]    seed_q;
  logic [SYM_W-1:0]    reel0_q, reel1_q, reel2_q;
  logic                busy_q;
  logic                done_q;
  logic [RES_W-1:0]    result_q;
  logic [RES_W-1:0]    result_d;
  logic                stop_req;
  logic                stag_end;

  reel_scorer u_scorer (
    .sym0_i   (reel0_q),
    .sym1_i   (reel1_q),
    .sym2_i   (reel2_q),
    .result_o (result_d)
  );

  // Early stops are dropped, not queued: only the current-cycle pulse counts.
  assign stop_req = (stop_i && (cnt_q >= MIN_LAST)) || (cnt_q == AUTO_LAST);
  assign stag_end = (cnt_q == STAG_LAST);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rng_rst_q <= 1'b0;
      rng_en_q  <= '0;
      seed_q    <= '0;
      reel0_q   <= '0;
      reel1_q   <= '0;
      reel2_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= RESULT_NONE;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            seed_q    <= seed_in_i;
            busy_q    <= 1'b1;
            rng_rst_q <= 1'b1;
            rng_en_q  <= '0;
            reel0_q   <= '0;
            reel1_q   <= '0;
            reel2_q   <= '0;
            result_q  <= RESULT_NONE;
          end
        end

        ST_CLEAR: begin
          state_q   <= ST_SPIN;
          cnt_q     <= '0;
          rng_rst_q <= 1'b0;
          rng_en_q  <= 3'b111;
        end

        ST_SPIN: begin
          if (stop_req) begin
            state_q  <= ST_STOP0;
            cnt_q    <= '0;
            reel0_q  <= rand0_i;
            rng_en_q <= 3'b110;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_STOP0: begin
          if (stag_end) begin
            state_q  <= ST_STOP1;
            cnt_q    <= '0;
            reel1_q  <= rand1_i;
            rng_en_q <= 3'b100;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_STOP1: begin
          if (stag_end) begin
            state_q  <= ST_STOP2;
            cnt_q    <= '0;
            reel2_q  <= rand2_i;
            rng_en_q <= 3'b000;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // Result and done are registered on entry so both are visible
        // during the SCORE cycle itself.
        ST_STOP2: begin
          if (stag_end) begin
            state_q  <= ST_SCORE;
            cnt_q    <= '0;
            result_q <= result_d;
            done_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_SCORE: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          rng_rst_q <= 1'b0;
          rng_en_q  <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign rng_rst_o  = rng_rst_q;
  assign rng_en_o   = rng_en_q;
  assign rng_seed_o = seed_q;
  assign reel0_o    = reel0_q;
  assign reel1_o    = reel1_q;
  assign reel2_o    = reel2_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;

endmodule

// File: tb/tb_reel_spin_ctrl.sv
// Directed bench for reel_spin_ctrl with short timing parameters: table of
// scoring vectors plus hand sequences for latency, early stop, ignored
// inputs and mid-spin reset.
module tb_reel_spin_ctrl;
  import slot_pkg::*;

  localparam int SPIN_MIN  = 4;
  localparam int AUTO_STOP = 20;
  localparam int STAGGER   = 2;
  localparam int CNT_W     = 11;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, stop;
  logic [2:0] seed_in, rand0, rand1, rand2;
  logic       rng_rst;
  logic [2:0] rng_en, rng_seed, reel0, reel1, reel2;
  logic       busy, done;
  logic [1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reel_spin_ctrl #(
    .SPIN_MIN (SPIN_MIN),
    .AUTO_STOP(AUTO_STOP),
    .STAGGER  (STAGGER),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .start_i   (start),
    .stop_i    (stop),
    .seed_in_i (seed_in),
    .rand0_i   (rand0),
    .rand1_i   (rand1),
    .rand2_i   (rand2),
    .rng_rst_o (rng_rst),
    .rng_en_o  (rng_en),
    .rng_seed_o(rng_seed),
    .reel0_o   (reel0),
    .reel1_o   (reel1),
    .reel2_o   (reel2),
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (result)
  );

  typedef struct {
    logic [2:0] r0, r1, r2;
    logic [1:0] res;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rng_rst"}, 32'(rng_rst), 32'(0));
    check({tag, "_rng_en"},  32'(rng_en),  32'(0));
    check({tag, "_seed"},    32'(rng_seed), 32'(0));
    check({tag, "_reels"},   32'({reel0, reel1, reel2}), 32'(0));
    check({tag, "_busy"},    32'(busy),    32'(0));
    check({tag, "_done"},    32'(done),    32'(0));
    check({tag, "_result"},  32'(result),  32'(0));
  endtask

  // Leaves the bench in cycle 1 (CLEAR) after the pulse.
  task automatic pulse_start(input logic [2:0] seed);
    seed_in = seed;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done), 32'(1));
  endtask

  initial begin
    int n;

    vecs[0] = '{r0: 3'b101, r1: 3'b101, r2: 3'b101, res: 2'b10};
    vecs[1] = '{r0: 3'b101, r1: 3'b101, r2: 3'b010, res: 2'b01};
    vecs[2] = '{r0: 3'b001, r1: 3'b010, r2: 3'b100, res: 2'b00};
    vecs[3] = '{r0: 3'b011, r1: 3'b100, r2: 3'b011, res: 2'b01};
    vecs[4] = '{r0: 3'b000, r1: 3'b111, r2: 3'b111, res: 2'b01};
    vecs[5] = '{r0: 3'b000, r1: 3'b000, r2: 3'b000, res: 2'b10};
    vecs[6] = '{r0: 3'b111, r1: 3'b110, r2: 3'b101, res: 2'b00};
    vecs[7] = '{r0: 3'b110, r1: 3'b010, r2: 3'b110, res: 2'b01};

    reset_n = 1'b0;
    start = 1'b0; stop = 1'b0;
    seed_in = 3'b000; rand0 = 3'b000; rand1 = 3'b000; rand2 = 3'b000;
    tick();
    tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Scoring table: stop exactly at the earliest honoured count (cnt=3).
    foreach (vecs[i]) begin
      rand0 = vecs[i].r0; rand1 = vecs[i].r1; rand2 = vecs[i].r2;
      pulse_start(3'b011);
      for (int c = 0; c < 4; c++) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("vec_stop0_en", 32'(rng_en), 32'(3'b110));
      wait_done(20, n);
      check("vec_stop_latency", 32'(n), 32'(6));
      check("vec_reel0", 32'(reel0), 32'(vecs[i].r0));
      check("vec_reel1", 32'(reel1), 32'(vecs[i].r1));
      check("vec_reel2", 32'(reel2), 32'(vecs[i].r2));
      check("vec_result", 32'(result), 32'(vecs[i].res));
      tick();
      check("vec_busy_after", 32'(busy), 32'(0));
      check("vec_done_pulse", 32'(done), 32'(0));
      check("vec_result_hold", 32'(result), 32'(vecs[i].res));
      tick();
    end

    // Auto-stop with staggered freezes, ignored starts, seed hold and latch timing.
    rand0 = 3'd1; rand1 = 3'd2; rand2 = 3'd3;
    pulse_start(3'b110);
    check("auto_rng_rst", 32'(rng_rst), 32'(1));
    check("auto_busy", 32'(busy), 32'(1));
    check("auto_clear_en", 32'(rng_en), 32'(0));
    check("auto_clear_reels", 32'({reel0, reel1, reel2}), 32'(0));
    check("auto_clear_result", 32'(result), 32'(0));
    check("auto_seed", 32'(rng_seed), 32'(3'b110));
    for (int cyc = 2; cyc <= 29; cyc++) begin
      logic [2:0] exp_en;
      tick();
      if (cyc <= 21)      exp_en = 3'b111;
      else if (cyc <= 23) exp_en = 3'b110;
      else if (cyc <= 25) exp_en = 3'b100;
      else                exp_en = 3'b000;
      check("auto_en", 32'(rng_en), 32'(exp_en));
      check("auto_done", 32'(done), 32'(cyc == 28));
      check("auto_busy_cyc", 32'(busy), 32'(cyc <= 28));
      check("auto_rng_rst_low", 32'(rng_rst), 32'(0));
      check("auto_seed_hold", 32'(rng_seed), 32'(3'b110));
      if (cyc == 5 || cyc == 24) begin
        start = 1'b1; seed_in = 3'b001;
      end else begin
        start = 1'b0;
      end
      if (cyc == 22) begin
        rand0 = 3'd4; rand1 = 3'd5; rand2 = 3'd6;
      end
      if (cyc == 24) begin
        rand0 = 3'd7; rand1 = 3'd7; rand2 = 3'd7;
      end
      if (cyc == 28) begin
        check("auto_reel0", 32'(reel0), 32'(1));
        check("auto_reel1", 32'(reel1), 32'(5));
        check("auto_reel2", 32'(reel2), 32'(7));
        check("auto_result", 32'(result), 32'(2'b00));
      end
    end
    start = 1'b0;

    // Stop while idle is ignored.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("idle_stop_busy", 32'(busy), 32'(0));
    check("idle_stop_en", 32'(rng_en), 32'(0));

    // Early stop dropped at cnt=2, honoured at cnt=6.
    rand0 = 3'd6; rand1 = 3'd6; rand2 = 3'd1;
    pulse_start(3'b010);
    tick(); tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("early_stop_ignored", 32'(rng_en), 32'(3'b111));
    tick(); tick(); tick();
    check("early_still_spin", 32'(rng_en), 32'(3'b111));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("late_stop_stop0", 32'(rng_en), 32'(3'b110));
    wait_done(20, n);
    check("late_stop_latency", 32'(n), 32'(6));
    check("late_stop_result", 32'(result), 32'(2'b01));
    tick();

    // Start and stop together in idle: start wins, full auto latency follows.
    rand0 = 3'd2; rand1 = 3'd4; rand2 = 3'd2;
    seed_in = 3'b101;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("both_rng_rst", 32'(rng_rst), 32'(1));
    check("both_seed", 32'(rng_seed), 32'(3'b101));
    wait_done(60, n);
    check("both_latency", 32'(n), 32'(27));
    check("both_result", 32'(result), 32'(2'b01));
    tick();

    // Asynchronous reset in the middle of STOP1.
    rand0 = 3'd3; rand1 = 3'd3; rand2 = 3'd3;
    pulse_start(3'b111);
    for (int c = 2; c <= 24; c++) tick();
    check("pre_reset_en", 32'(rng_en), 32'(3'b100));
    check("pre_reset_reel0", 32'(reel0), 32'(3));
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    for (int c = 0; c < 4; c++) begin
      tick();
      check("midreset_no_done", 32'(done), 32'(0));
    end
    #2;
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("post_reset_idle_done", 32'(done), 32'(0));
      check("post_reset_idle_busy", 32'(busy), 32'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
